sdram_device_model: RTL and testbench
=====================================

Name: sdram_device_model

Overview:
- Cycle-accurate SDR SDRAM responder: the device side of the SDRAM pin interface driven by the team's SDRAM controller.
- Decodes commands, tracks per-bank open rows and timing, stores data in an internal array, and returns read data after the programmed CAS latency.
- Used in the user-project testbench and in FPGA bring-up builds in place of real SDRAM.
- Flags protocol and timing violations for the verification environment.

Parameters:
- ROW_BITS, 4: implemented row-address bits. Upper row bits are ignored (aliased).
- COL_BITS, 8: column bits, taken from sdram_a[COL_BITS+1:2].
- CAS_LAT, 2: reset CAS latency in cycles, legal values 1..3.
- T_RCD, 2: minimum cycles from ACTIVE to READ/WRITE on the same bank.
- T_RP, 2: minimum cycles from PRECHARGE to ACTIVE/REFRESH.
- T_RFC, 6: minimum cycles from REFRESH to any non-NOP command.

Ports:
- clk, input, 1: clock. Reset is rst: synchronous, active-high; clock is clk.
- rst, input, 1: synchronous reset.
- sdram_cle, input, 1: clock enable. When low, all commands are ignored.
- sdram_cs, input, 1: command bit 3.
- sdram_ras, input, 1: command bit 2.
- sdram_cas, input, 1: command bit 1.
- sdram_we, input, 1: command bit 0.
- sdram_dqm, input, 1: write mask. When high during WRITE, the store is suppressed.
- sdram_ba, input, 2: bank address.
- sdram_a, input, 13: row address (ACTIVE), column address in [9:2], auto-precharge / all-bank bit in [10], mode in [6:4] (LMR).
- sdram_dqi, input, 32: write data, sampled in the same cycle as WRITE.
- sdram_dqo, output, 32: read data.
- err, output, 1: sticky protocol-violation flag.
- err_code, output, 3: code of the first violation.

Behaviour:
- Command decode {cs,ras,cas,we} is sampled at each posedge when cle=1:
  - 1xxx = deselect.
  - 0111 = NOP.
  - 0011 = ACTIVE.
  - 0101 = READ.
  - 0100 = WRITE.
  - 0110 = TERMINATE (treated as NOP).
  - 0010 = PRECHARGE.
  - 0001 = REFRESH.
  - 0000 = LMR.
- Reset values:
  - sdram_dqo=0, err=0, err_code=0.
  - All banks IDLE, all timers 0.
  - CL register = CAS_LAT; read pipeline empty.
  - Array contents are not reset.
- Per-bank FSM, two states:
  - IDLE -> ACTIVE on ACTIVE: latch row = a[ROW_BITS-1:0], load tRCD timer = T_RCD.
  - ACTIVE -> IDLE on PRECHARGE to the bank, or with a[10]=1 (all banks): load tRP timer = T_RP.
  - PRECHARGE to an IDLE bank is legal and only reloads tRP.
- Global tRFC timer is loaded on REFRESH. All timers decrement to 0 each enabled cycle.
- WRITE to an ACTIVE bank with tRCD=0:
  - Writes mem[{ba,row,col}] = sdram_dqi at that edge unless dqm=1.
  - Zero latency; a READ of the same address on the next cycle returns the new data.
- READ to an ACTIVE bank with tRCD=0:
  - Captures mem[{ba,row,col}] into a CL-deep pipeline.
  - sdram_dqo shows that data in the cycle after edge N+CL, where edge N sampled the READ.
  - sdram_dqo holds its value until the next read result arrives.
- Back-to-back READs every cycle are supported. Results emerge in order, one per cycle, and may target any active banks.
- LMR with all banks IDLE: CL = a[6:4] when that is 1..3; otherwise CL is unchanged and err_code=6 is raised.
- CL change with reads in flight: in-flight reads complete at the old latency.
- cle=0: command ignored, timers and read pipeline frozen, sdram_dqo held.
- Violations set err=1, latch err_code on the first violation only, and leave the command ignored. Codes:
  - 1: READ/WRITE to an IDLE bank.
  - 2: ACTIVE to an ACTIVE bank.
  - 3: tRCD violated.
  - 4: tRP violated on ACTIVE/REFRESH.
  - 5: REFRESH with any bank ACTIVE, or any non-NOP command while tRFC≠0.
  - 6: LMR with a bank open or an illegal CL.
  - 7: a[10]=1 on READ/WRITE (auto-precharge not supported).
- err clears only on rst.
- Reset mid-read: the pipeline is flushed, sdram_dqo=0, and banks go IDLE.

Test Plan:
- Bring-up write/read: ACTIVE ba=1 row=3; wait 2 NOPs; WRITE col=0x10 data=0xDEADBEEF; READ col=0x10 -> sdram_dqo=0xDEADBEEF in the cycle after edge N+2; err=0.
- Streaming read: preload col 0..3 with 0x100..0x103; issue 4 consecutive READs -> sdram_dqo shows 0x100,0x101,0x102,0x103 on consecutive cycles, CL=2.
- Timing violations:
  - READ 1 cycle after ACTIVE -> err=1, err_code=3, sdram_dqo unchanged.
  - New run: ACTIVE 1 cycle after PRECHARGE -> err_code=4.
- Refresh rules:
  - PRECHARGE all (a[10]=1); wait T_RP; REFRESH; ACTIVE at +3 cycles -> err_code=5.
  - Clean run with ACTIVE at +6 cycles -> err=0.
- LMR and mask:
  - LMR a[6:4]=3 -> read latency becomes 3 cycles.
  - WRITE with dqm=1 -> old data retained on readback.
  - LMR a[6:4]=5 -> err_code=6 and CL stays 3.
- cle and reset: cle=0 for 3 cycles mid-read -> data delayed by exactly 3 cycles. rst asserted during in-flight READ -> sdram_dqo=0 and the result is never emitted.

Source files
------------

// File: rtl/sdram_device_model_if.sv
// SDRAM pin bundle between the controller (master) and the device model (slave).
//   sdram_cle/cs/ras/cas/we : clock enable and command bits
//   sdram_dqm               : write mask
//   sdram_ba / sdram_a      : bank / address
//   sdram_dqi / sdram_dqo   : write data in / read data out
//   err / err_code          : sticky violation flag and first violation code
interface sdram_device_model_if;
  logic        sdram_cle;
  logic        sdram_cs;
  logic        sdram_ras;
  logic        sdram_cas;
  logic        sdram_we;
  logic        sdram_dqm;
  logic [1:0]  sdram_ba;
  logic [12:0] sdram_a;
  logic [31:0] sdram_dqi;
  logic [31:0] sdram_dqo;
  logic        err;
  logic [2:0]  err_code;

  modport master (
    output sdram_cle, sdram_cs, sdram_ras, sdram_cas, sdram_we, sdram_dqm,
           sdram_ba, sdram_a, sdram_dqi,
    input  sdram_dqo, err, err_code
  );

  modport slave (
    input  sdram_cle, sdram_cs, sdram_ras, sdram_cas, sdram_we, sdram_dqm,
           sdram_ba, sdram_a, sdram_dqi,
    output sdram_dqo, err, err_code
  );
endinterface

// File: rtl/sdram_device_model.sv
// Cycle-accurate SDR SDRAM device responder. Decodes commands, tracks per-bank
// open rows and tRCD/tRP/tRFC windows, stores data in an internal array and
// returns read data after the programmed CAS latency. Violations are flagged.
//   clk, rst : clock, synchronous active-high reset
//   bus      : SDRAM pin bundle (slave side)
module sdram_device_model #(
  parameter int ROW_BITS = 4,
  parameter int COL_BITS = 8,
  parameter int CAS_LAT  = 2,
  parameter int T_RCD    = 2,
  parameter int T_RP     = 2,
  parameter int T_RFC    = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  sdram_device_model_if.slave  bus
);
  localparam int TMAX = (T_RFC > T_RCD) ? ((T_RFC > T_RP) ? T_RFC : T_RP)
                                        : ((T_RCD > T_RP) ? T_RCD : T_RP);
  localparam int TW   = $clog2(TMAX + 1);
  localparam int AW   = 2 + ROW_BITS + COL_BITS;
  localparam int PD   = 3;  // deepest legal CAS latency

  localparam logic [3:0] C_NOP  = 4'b0111, C_ACT = 4'b0011, C_RD  = 4'b0101,
                         C_WR   = 4'b0100, C_TERM = 4'b0110, C_PRE = 4'b0010,
                         C_REF  = 4'b0001, C_LMR = 4'b0000;

  typedef enum logic {B_IDLE, B_ACT} bank_st_e;
  typedef struct packed {
    logic        vld;
    logic [31:0] dat;
  } rd_slot_t;

  bank_st_e              st_q   [4], st_d   [4];
  logic [ROW_BITS-1:0]   row_q  [4], row_d  [4];
  logic [TW-1:0]         trcd_q [4], trcd_d [4];
  logic [TW-1:0]         trp_q  [4], trp_d  [4];
  logic [TW-1:0]         trfc_q, trfc_d;
  logic [1:0]            cl_q, cl_d;
  rd_slot_t              slot_q [PD], slot_d [PD];
  logic [31:0]           dqo_q, dqo_d;
  logic                  err_q, err_d;
  logic [2:0]            code_q, code_d;

  logic [31:0] mem [2**AW];

  logic [3:0]    cmd;
  logic          idle_cmd, any_open, any_trp, viol, wr_en, rd_en;
  logic [2:0]    vcode;
  logic [1:0]    ba;
  logic [AW-1:0] mem_addr;
  logic          unused_ok;

  assign cmd      = {bus.sdram_cs, bus.sdram_ras, bus.sdram_cas, bus.sdram_we};
  assign idle_cmd = bus.sdram_cs | (cmd == C_NOP) | (cmd == C_TERM);
  assign ba       = bus.sdram_ba;
  assign mem_addr = {ba, row_q[ba], bus.sdram_a[COL_BITS+1:2]};
  assign unused_ok = ^bus.sdram_a;

  // A timer value of 1 at an edge means the window closes on this very edge:
  // a command arriving exactly T cycles after the loading command is legal.
  always_comb begin
    any_open = 1'b0;
    any_trp  = 1'b0;
    for (int b = 0; b < 4; b++) begin
      st_d[b]   = st_q[b];
      row_d[b]  = row_q[b];
      trcd_d[b] = (trcd_q[b] != '0) ? trcd_q[b] - 1'b1 : '0;
      trp_d[b]  = (trp_q[b]  != '0) ? trp_q[b]  - 1'b1 : '0;
      any_open  = any_open | (st_q[b] == B_ACT);
      any_trp   = any_trp  | (trp_q[b] > TW'(1));
    end
    trfc_d = (trfc_q != '0) ? trfc_q - 1'b1 : '0;
    cl_d   = cl_q;
    viol   = 1'b0;
    vcode  = 3'd0;
    wr_en  = 1'b0;
    rd_en  = 1'b0;

    if (!idle_cmd) begin
      if (trfc_q > TW'(1)) begin
        viol = 1'b1; vcode = 3'd5;
      end else begin
        case (cmd)
          C_ACT:
            if (st_q[ba] == B_ACT)       begin viol = 1'b1; vcode = 3'd2; end
            else if (trp_q[ba] > TW'(1)) begin viol = 1'b1; vcode = 3'd4; end
            else begin
              st_d[ba]   = B_ACT;
              row_d[ba]  = bus.sdram_a[ROW_BITS-1:0];
              trcd_d[ba] = TW'(T_RCD);
            end
          C_RD, C_WR:
            if (st_q[ba] == B_IDLE)       begin viol = 1'b1; vcode = 3'd1; end
            else if (bus.sdram_a[10])     begin viol = 1'b1; vcode = 3'd7; end
            else if (trcd_q[ba] > TW'(1)) begin viol = 1'b1; vcode = 3'd3; end
            else if (cmd == C_RD)         rd_en = 1'b1;
            else                          wr_en = ~bus.sdram_dqm;
          C_PRE:
            for (int b = 0; b < 4; b++)
              if (bus.sdram_a[10] || (2'(b) == ba)) begin
                st_d[b]  = B_IDLE;
                trp_d[b] = TW'(T_RP);
              end
          C_REF:
            if (any_open)     begin viol = 1'b1; vcode = 3'd5; end
            else if (any_trp) begin viol = 1'b1; vcode = 3'd4; end
            else              trfc_d = TW'(T_RFC);
          C_LMR:
            if (any_open || bus.sdram_a[6:4] == 3'd0 || bus.sdram_a[6])
              begin viol = 1'b1; vcode = 3'd6; end
            else cl_d = bus.sdram_a[5:4];
          default: ;
        endcase
      end
    end
  end

  // Read pipeline: slot i emerges on dqo i+1 edges from now. A new read is
  // placed at depth CL-1, so later CL changes never retime reads in flight.
  always_comb begin
    for (int i = 0; i < PD - 1; i++) slot_d[i] = slot_q[i+1];
    slot_d[PD-1] = '0;
    if (rd_en)
      for (int i = 0; i < PD; i++)
        if (cl_q == 2'(i + 1)) slot_d[i] = '{vld: 1'b1, dat: mem[mem_addr]};
    dqo_d  = slot_q[0].vld ? slot_q[0].dat : dqo_q;
    err_d  = err_q | viol;
    code_d = (viol && !err_q) ? vcode : code_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int b = 0; b < 4; b++) begin
        st_q[b]   <= B_IDLE;
        row_q[b]  <= '0;
        trcd_q[b] <= '0;
        trp_q[b]  <= '0;
      end
      for (int i = 0; i < PD; i++) slot_q[i] <= '0;
      trfc_q <= '0;
      cl_q   <= 2'(CAS_LAT);
      dqo_q  <= '0;
      err_q  <= 1'b0;
      code_q <= 3'd0;
    end else if (bus.sdram_cle) begin
      for (int b = 0; b < 4; b++) begin
        st_q[b]   <= st_d[b];
        row_q[b]  <= row_d[b];
        trcd_q[b] <= trcd_d[b];
        trp_q[b]  <= trp_d[b];
      end
      for (int i = 0; i < PD; i++) slot_q[i] <= slot_d[i];
      trfc_q <= trfc_d;
      cl_q   <= cl_d;
      dqo_q  <= dqo_d;
      err_q  <= err_d;
      code_q <= code_d;
    end
  end

  // Storage survives reset on purpose.
  always_ff @(posedge clk)
    if (!rst && bus.sdram_cle && wr_en) mem[mem_addr] <= bus.sdram_dqi;

  assign bus.sdram_dqo = dqo_q;
  assign bus.err       = err_q;
  assign bus.err_code  = code_q;
endmodule

// File: tb/tb_sdram_device_model.sv
module tb_sdram_device_model;
  localparam logic [3:0] NOP = 4'b0111, ACT = 4'b0011, RD = 4'b0101, WR = 4'b0100,
                         PRE = 4'b0010, REF = 4'b0001, LMR = 4'b0000;

  logic clk, rst;
  int   total = 0;
  int   bad   = 0;

  sdram_device_model_if bus();
  sdram_device_model dut (.clk(clk), .rst(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive the command, take the edge, settle 1 time unit past it.
  task automatic cyc(input logic [3:0] c, input int b = 0, input int a = 0,
                     input logic [31:0] d = 32'h0, input logic m = 1'b0);
    {bus.sdram_cs, bus.sdram_ras, bus.sdram_cas, bus.sdram_we} = c;
    bus.sdram_ba  = 2'(b);
    bus.sdram_a   = 13'(a);
    bus.sdram_dqi = d;
    bus.sdram_dqm = m;
    @(posedge clk);
    #1;
  endtask

  task automatic nop();                        cyc(NOP);                   endtask
  task automatic act(input int b, input int r); cyc(ACT, b, r);            endtask
  task automatic rd(input int b, input int c);  cyc(RD, b, c << 2);        endtask
  task automatic wr(input int b, input int c, input logic [31:0] d, input logic m = 1'b0);
    cyc(WR, b, c << 2, d, m);
  endtask
  task automatic pre_all();                     cyc(PRE, 0, 13'h400);      endtask
  task automatic lmr(input int cl);             cyc(LMR, 0, cl << 4);      endtask
  task automatic do_reset();
    rst = 1'b1; nop(); nop(); rst = 1'b0;
  endtask

  initial begin
    bus.sdram_cle = 1'b1;
    do_reset();
    chk("rst_dqo", bus.sdram_dqo, 32'h0);
    chk("rst_err", 32'(bus.err), 0);
    chk("rst_code", 32'(bus.err_code), 0);

    // bring-up write/read, CL=2
    act(1, 3); nop(); nop();
    wr(1, 16, 32'hDEADBEEF);
    rd(1, 16);
    nop(); chk("bu_early", bus.sdram_dqo, 32'h0);
    nop(); chk("bu_data", bus.sdram_dqo, 32'hDEADBEEF);
    chk("bu_err", 32'(bus.err), 0);

    // streaming reads
    for (int i = 0; i < 4; i++) wr(1, i, 32'h100 + 32'(i));
    rd(1, 0); chk("st_r0", bus.sdram_dqo, 32'hDEADBEEF);
    rd(1, 1); chk("st_r1", bus.sdram_dqo, 32'hDEADBEEF);
    rd(1, 2); chk("st_d0", bus.sdram_dqo, 32'h100);
    rd(1, 3); chk("st_d1", bus.sdram_dqo, 32'h101);
    nop();    chk("st_d2", bus.sdram_dqo, 32'h102);
    nop();    chk("st_d3", bus.sdram_dqo, 32'h103);
    nop();    chk("st_hold", bus.sdram_dqo, 32'h103);

    // masked write keeps old data
    wr(1, 16, 32'h12345678, 1'b1);
    rd(1, 16); nop(); nop();
    chk("dqm_keep", bus.sdram_dqo, 32'hDEADBEEF);
    chk("dqm_err", 32'(bus.err), 0);

    // LMR to CL=3
    pre_all(); nop(); lmr(3); act(1, 3); nop(); nop();
    rd(1, 1);
    nop(); chk("cl3_e1", bus.sdram_dqo, 32'hDEADBEEF);
    nop(); chk("cl3_e2", bus.sdram_dqo, 32'hDEADBEEF);
    nop(); chk("cl3_data", bus.sdram_dqo, 32'h101);
    chk("cl3_err", 32'(bus.err), 0);

    // illegal CL
    pre_all(); nop(); nop(); lmr(5);
    chk("lmr5_err", 32'(bus.err), 1);
    chk("lmr5_code", 32'(bus.err_code), 6);
    act(1, 3); nop(); nop();
    rd(1, 2); nop();
    nop(); chk("lmr5_e2", bus.sdram_dqo, 32'h101);
    nop(); chk("lmr5_cl3", bus.sdram_dqo, 32'h102);

    // cle low for 3 cycles mid-read (reads issued while stalled are ignored)
    rd(1, 3);
    bus.sdram_cle = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rd(1, 0); chk("cle_frozen", bus.sdram_dqo, 32'h102);
    end
    bus.sdram_cle = 1'b1;
    nop(); chk("cle_e1", bus.sdram_dqo, 32'h102);
    nop(); chk("cle_e2", bus.sdram_dqo, 32'h102);
    nop(); chk("cle_data", bus.sdram_dqo, 32'h103);
    nop(); chk("cle_hold", bus.sdram_dqo, 32'h103);

    // reset with a read in flight
    rd(1, 0); nop();
    rst = 1'b1; nop();
    chk("rr_dqo", bus.sdram_dqo, 32'h0);
    chk("rr_err", 32'(bus.err), 0);
    rst = 1'b0;
    nop(); nop(); nop();
    chk("rr_flushed", bus.sdram_dqo, 32'h0);

    // tRCD violation
    act(0, 5); rd(0, 0);
    chk("trcd_err", 32'(bus.err), 1);
    chk("trcd_code", 32'(bus.err_code), 3);
    nop(); nop(); nop();
    chk("trcd_dqo", bus.sdram_dqo, 32'h0);

    // tRP violation
    do_reset();
    act(2, 1); nop(); nop(); cyc(PRE, 2, 0); act(2, 1);
    chk("trp_code", 32'(bus.err_code), 4);

    // ACTIVE too soon after REFRESH
    do_reset();
    pre_all(); nop(); nop(); cyc(REF); nop(); nop(); act(1, 3);
    chk("trfc_err", 32'(bus.err), 1);
    chk("trfc_code", 32'(bus.err_code), 5);

    // clean refresh; CL back to 2, array retained across reset
    do_reset();
    pre_all(); nop(); nop(); cyc(REF);
    for (int i = 0; i < 5; i++) nop();
    act(1, 3);
    chk("ref_ok", 32'(bus.err), 0);
    nop(); nop(); rd(1, 16);
    nop(); chk("ref_e1", bus.sdram_dqo, 32'h0);
    nop(); chk("ref_data", bus.sdram_dqo, 32'hDEADBEEF);
    chk("ref_err", 32'(bus.err), 0);

    // idle-bank access, first code sticks
    do_reset();
    rd(3, 0);
    chk("idle_code", 32'(bus.err_code), 1);
    act(0, 0); act(0, 0);
    chk("first_code", 32'(bus.err_code), 1);
    chk("first_err", 32'(bus.err), 1);

    // ACTIVE to open bank
    do_reset();
    act(0, 0); act(0, 0);
    chk("actact_code", 32'(bus.err_code), 2);

    // auto-precharge bit on READ
    do_reset();
    act(0, 0); nop(); nop(); cyc(RD, 0, 13'h400);
    chk("ap_code", 32'(bus.err_code), 7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
